rr_arb8: RTL and testbench
==========================

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter MAXHOLD, default 16: maximum cycles a grant may be held; 0 disables the limit.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  arbitration enable; while low, no new grant is issued.
REQ-005 req  input  8  request vector, bit i = requester i.
REQ-006 done  input  1  release strobe from the current grant holder.
REQ-007 gnt  output  8  one-hot grant vector, equal to the 3-to-8 decode of idx gated by valid.
REQ-008 idx  output  3  binary index of the granted requester.
REQ-009 valid  output  1  a grant is active.
REQ-010 tout  output  1  one-cycle pulse on a forced release by MAXHOLD.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 In IDLE, with en=1 and req!=0 sampled at edge k, the block SHALL enter GRANT at edge k, with valid=1, idx=winner and gnt=one-hot(winner) registered at that same edge.
REQ-013 The winner SHALL be the first set req bit searching upward from (ptr+1) mod 8 with wrap-around; ptr is the last granted index.
REQ-014 ptr SHALL update to the winner on entry to GRANT and SHALL NOT change otherwise.
REQ-015 In IDLE, with en=0 or req=0, the block SHALL remain in IDLE with gnt=0, valid=0 and idx holding its last value.
REQ-016 In GRANT, idx and gnt SHALL remain stable until release, regardless of the other req bits or en.
REQ-017 Release condition at edge m: done=1, OR req[idx]=0, OR (MAXHOLD!=0 and the hold count equals MAXHOLD-1).
REQ-018 On release, the block SHALL return to IDLE at edge m; gnt=0 and valid=0 after edge m; the earliest next grant is at edge m+1 (mandatory one-cycle gap).
REQ-019 The hold counter SHALL clear to 0 on entry to GRANT, increment by 1 each cycle in GRANT, and be wide enough for MAXHOLD-1 without wrap.
REQ-020 tout SHALL be 1 for exactly the cycle after edge m, and only when the release was caused solely by MAXHOLD (done=0 and req[idx]=1).
REQ-021 Simultaneous done and timeout SHALL count as a normal release: tout=0.
REQ-022 gnt SHALL be one-hot or all-zero at all times; gnt!=0 SHALL occur if and only if valid=1.
REQ-023 done sampled while in IDLE SHALL be ignored.
REQ-024 en going low during GRANT SHALL NOT terminate the current grant.

Reset
REQ-025 rst=1 sampled at any edge, including mid-grant, SHALL force IDLE, gnt=0, valid=0, idx=0, tout=0, hold count=0 and ptr=7, so the first search starts at requester 0.
REQ-026 While rst=1 no grant SHALL be issued; arbitration resumes at the first edge with rst=0.

Verification
REQ-027 Reset, then req=8'b1000_0001, en=1 held -> grants idx=0, then after release and gap idx=7, then idx=0 (alternating).
REQ-028 req=8'hFF constant, done pulsed one cycle after each grant -> idx sequence 0,1,...,7,0 with gnt=8'h01,8'h02,... and a one-cycle gnt=0 gap between grants.
REQ-029 MAXHOLD=16, req=8'h04 held, done=0 -> valid high for exactly 16 cycles, tout pulses once, then after a one-cycle gap idx=2 is regranted.
REQ-030 Grant to idx=3, then rst=1 for one cycle mid-grant -> gnt=0, valid=0 next cycle; with req=8'h08 held, the next grant is idx=3 (search from 0).
REQ-031 en=0 with req=8'h10 -> no grant; raise en at edge k -> gnt=8'h10 registered at edge k; drop en during the grant -> grant held until done.
REQ-032 Grant to idx=5 with req[5] dropped and done=0 -> release at that edge, tout=0, ptr=5 for the next search.

Source files
------------

// File: rtl/rr_arb8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb8
//  Description : Eight-way round-robin arbiter with a two-state IDLE/GRANT FSM,
//                registered one-hot grant, release on done / request drop /
//                hold-limit, and a one-cycle timeout pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb8 #(
    parameter int MAXHOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] idx,
    output logic       valid,
    output logic       tout
);

    // Hold counter only ever needs to reach MAXHOLD-1.
    localparam int c_HOLD_W = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST =
        c_HOLD_W'((MAXHOLD > 0) ? (MAXHOLD - 1) : 0);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0]          r_state;
    logic [2:0]          r_ptr;
    logic [2:0]          r_idx;
    logic [7:0]          r_gnt;
    logic                r_tout;
    logic [c_HOLD_W-1:0] r_hold;

    logic [2:0]          w_win;
    logic                w_any;
    logic                w_timeout;
    logic                w_release;

    // Rotating priority search: first set request above the last winner.
    always_comb begin
        logic [2:0] w_cand;
        w_win  = 3'd0;
        w_any  = 1'b0;
        w_cand = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            w_cand = r_ptr + 3'(i);
            if (!w_any && req[w_cand]) begin
                w_win = w_cand;
                w_any = 1'b1;
            end
        end
    end

    // Release decode for the current holder; timeout is inert when MAXHOLD=0.
    always_comb begin
        w_timeout = (MAXHOLD != 0) && (r_hold == c_HOLD_LAST);
        w_release = done || !req[r_idx] || w_timeout;
    end

    // Arbitration FSM, grant registers, pointer, hold counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= 3'd7;
            r_idx   <= 3'd0;
            r_gnt   <= 8'd0;
            r_tout  <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_tout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (en && w_any) begin
                        r_state <= c_GRANT;
                        r_idx   <= w_win;
                        r_ptr   <= w_win;
                        r_gnt   <= 8'b1 << w_win;
                        r_hold  <= '0;
                    end
                end
                c_GRANT: begin
                    if (w_release) begin
                        r_state <= c_IDLE;
                        r_gnt   <= 8'd0;
                        // Pulse only when the hold limit alone forced the release.
                        r_tout  <= w_timeout && !done && req[r_idx];
                    end else begin
                        r_hold  <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_gnt   <= 8'd0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign idx   = r_idx;
    assign valid = (r_state == c_GRANT);
    assign tout  = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb8
//  Description : Scoreboard bench for rr_arb8 with a behavioural reference
//                model; directed scenarios followed by randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_arb8;

    localparam int MAXHOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       tout;

    rr_arb8 #(.MAXHOLD(MAXHOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .done  (done),
        .gnt   (gnt),
        .idx   (idx),
        .valid (valid),
        .tout  (tout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       tout;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle_no = 0;

    // Reference model: who owns the resource, who won last, how long it has been shown.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = 7;
    int m_shown = 0;
    bit m_tout  = 1'b0;

    task automatic model_step(input bit r, input bit e, input logic [7:0] q, input bit d);
        bit expired;
        m_tout = 1'b0;
        if (r) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = 7;
            m_shown = 0;
        end else if (m_busy) begin
            m_shown = m_shown + 1;
            expired = (MAXHOLD != 0) && (m_shown == MAXHOLD);
            if (d || !q[m_owner] || expired) begin
                m_busy = 1'b0;
                m_tout = expired && !d && q[m_owner];
            end
        end else if (e && q != 8'd0) begin
            for (int j = 1; j <= 8; j++) begin
                if (!m_busy && q[(m_last + j) % 8]) begin
                    m_owner = (m_last + j) % 8;
                    m_busy  = 1'b1;
                end
            end
            m_last  = m_owner;
            m_shown = 0;
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show after the edge.
    task automatic cyc(input bit r, input bit e, input logic [7:0] q, input bit d);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        req  = q;
        done = d;
        model_step(r, e, q, d);
        x.valid = m_busy;
        x.idx   = 3'(m_owner);
        x.gnt   = m_busy ? (8'd1 << m_owner) : 8'd0;
        x.tout  = m_tout;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycle_no, got, want);
        end
    endtask

    // Monitor: compare the DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("valid", {7'd0, valid}, {7'd0, x.valid});
                chk("idx",   {5'd0, idx},   {5'd0, x.idx});
                chk("gnt",   gnt,           x.gnt);
                chk("tout",  {7'd0, tout},  {7'd0, x.tout});
            end
        end
    end

    initial begin
        logic [7:0] rq;
        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'd0;
        done = 1'b0;

        cyc(1, 0, 8'h00, 0);
        cyc(1, 1, 8'hFF, 0);

        // Two requesters alternate: 0, 7, 0, ...
        for (int i = 0; i < 9; i++) cyc(0, 1, 8'h81, 1);

        // All requesting, immediate done: full rotation with gaps.
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 8'hFF, 1);

        // Hold limit: single requester never releases.
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 8'h04, 0);

        // Reset mid-grant, then search restarts from requester 0.
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'h08, 0);
        cyc(1, 1, 8'h08, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'h08, 0);
        cyc(0, 1, 8'h08, 1);

        // Enable gating: no grant while low, held grant survives en dropping.
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h10, 0);
        cyc(0, 1, 8'h10, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h10, 0);
        cyc(0, 0, 8'h10, 1);
        cyc(0, 0, 8'h10, 0);

        // Request drop releases without timeout; next search starts above 5.
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h20, 0);
        cyc(0, 1, 8'h00, 0);
        cyc(0, 1, 8'hFF, 0);
        cyc(0, 1, 8'hFF, 1);
        cyc(0, 1, 8'hE1, 0);

        // Done coinciding with the hold limit is a normal release.
        cyc(1, 0, 8'h00, 0);
        cyc(0, 1, 8'h40, 0);
        for (int i = 0; i < 15; i++) cyc(0, 1, 8'h40, 0);
        cyc(0, 1, 8'h40, 1);
        cyc(0, 1, 8'h40, 0);

        // Randomized traffic with sticky requests so hold limits are reached.
        rq = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0)
                rq = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 7) != 0),
                rq,
                ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
